// File: rtl/frame_double_buffer.sv
// Double-buffered ROWS x COLS bitmap ahead of the LED matrix scanner.
// The producer fills the back bank row by row; commit swaps banks at the next frame_sync.
module frame_double_buffer #(
  parameter int unsigned ROWS         = 16,
  parameter int unsigned COLS         = 16,
  parameter int unsigned RW           = 4,
  parameter bit          COPY_ON_SWAP = 1'b1
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [RW-1:0]         wr_row,
  input  logic [0:COLS-1]       wr_data,
  input  logic                  commit,
  input  logic                  frame_sync,
  output logic [0:ROWS*COLS-1]  mat,
  output logic                  pending,
  output logic                  swap_done,
  output logic [7:0]            frame_count
);

  typedef enum logic [0:0] {StIdle, StPending} state_e;

  state_e          state_q;
  logic            front_q;
  logic [0:COLS-1] bank_q [2][ROWS];
  logic            swap_done_q;
  logic [7:0]      count_q;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      front_q     <= 1'b0;
      swap_done_q <= 1'b0;
      count_q     <= 8'd0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank_q[b][r] <= '0;
        end
      end
    end else begin
      swap_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Rows >= ROWS match no entry, so such writes complete and are dropped.
          if (wr_valid) begin
            for (int r = 0; r < ROWS; r++) begin
              if (wr_row == RW'(r)) bank_q[~front_q][r] <= wr_data;
            end
          end
          if (commit) state_q <= StPending;
        end
        StPending: begin
          if (frame_sync) begin
            front_q     <= ~front_q;
            state_q     <= StIdle;
            swap_done_q <= 1'b1;
            count_q     <= count_q + 8'd1;
            // Old front becomes the back bank; seed it with the frame now on display.
            if (COPY_ON_SWAP) begin
              for (int r = 0; r < ROWS; r++) begin
                bank_q[front_q][r] <= bank_q[~front_q][r];
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    mat = '0;
    for (int r = 0; r < ROWS; r++) begin
      mat[r*COLS +: COLS] = bank_q[front_q][r];
    end
  end

  assign wr_ready    = (state_q == StIdle);
  assign pending     = (state_q == StPending);
  assign swap_done   = swap_done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_double_buffer.sv
// Directed bench for frame_double_buffer: vector table plus reset, reset-in-pending and wrap sequences.
module tb_frame_double_buffer;

  logic          clock;
  logic          rst_n;
  logic          wr_valid;
  logic          wr_ready;
  logic [4:0]    wr_row;
  logic [0:15]   wr_data;
  logic          commit;
  logic          frame_sync;
  logic [0:255]  mat;
  logic          pending;
  logic          swap_done;
  logic [7:0]    frame_count;

  frame_double_buffer #(
    .ROWS(16),
    .COLS(16),
    .RW(5),
    .COPY_ON_SWAP(1'b1)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_row(wr_row),
    .wr_data(wr_data),
    .commit(commit),
    .frame_sync(frame_sync),
    .mat(mat),
    .pending(pending),
    .swap_done(swap_done),
    .frame_count(frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic         wv;
    logic [4:0]   row;
    logic [15:0]  data;
    logic         cm;
    logic         fs;
    logic         e_ready;
    logic         e_pend;
    logic         e_swap;
    logic [7:0]   e_cnt;
    logic [0:255] e_mat;
  } vec_t;

  vec_t         vecs[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [0:255] zero_f;
  logic [0:255] fa;
  logic [0:255] fb;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wv, input logic [4:0] row, input logic [15:0] data,
                              input logic cm, input logic fs, input logic e_ready,
                              input logic e_pend, input logic e_swap, input logic [7:0] e_cnt,
                              input logic [0:255] e_mat);
    vec_t v;
    v.wv = wv; v.row = row; v.data = data; v.cm = cm; v.fs = fs;
    v.e_ready = e_ready; v.e_pend = e_pend; v.e_swap = e_swap; v.e_cnt = e_cnt; v.e_mat = e_mat;
    return v;
  endfunction

  task automatic idle_inputs();
    wr_valid = 1'b0; wr_row = '0; wr_data = '0; commit = 1'b0; frame_sync = 1'b0;
  endtask

  initial begin
    zero_f = '0;
    fa     = '0;
    for (int r = 0; r < 16; r++) fa[r*16 +: 16] = 16'h8001 | (16'd1 << r);
    fb           = fa;
    fb[0 +: 16]  = 16'h0F0F;

    // Full frame, commit with the last row, frozen-bank writes, sync five cycles after commit.
    for (int r = 0; r < 15; r++)
      vecs.push_back(mk(1, 5'(r), 16'h8001 | (16'd1 << r), 0, 0, 1, 0, 0, 8'd0, zero_f));
    vecs.push_back(mk(1, 5'd15, 16'h8001 | (16'd1 << 15), 1, 0, 0, 1, 0, 8'd0, zero_f));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk(1, 5'd3, 16'hFFFF, 0, 0, 0, 1, 0, 8'd0, zero_f));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 1, 1, 0, 1, 8'd1, fa));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 0, 1, 0, 0, 8'd1, fa));
    // frame_sync in IDLE does nothing.
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 1, 1, 0, 0, 8'd1, fa));
    // commit and frame_sync on the same edge: swap waits for the next sync.
    vecs.push_back(mk(0, 5'd0, 16'h0, 1, 1, 0, 1, 0, 8'd1, fa));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 0, 0, 1, 0, 8'd1, fa));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 0, 0, 1, 0, 8'd1, fa));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 1, 1, 0, 1, 8'd2, fa));
    // Incremental update right after a swap, write and commit on one edge.
    vecs.push_back(mk(1, 5'd0, 16'h0F0F, 1, 0, 0, 1, 0, 8'd2, fa));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 1, 1, 0, 1, 8'd3, fb));
    // Out-of-range row is accepted and dropped.
    vecs.push_back(mk(1, 5'd16, 16'hFFFF, 0, 0, 1, 0, 0, 8'd3, fb));
    vecs.push_back(mk(0, 5'd0, 16'h0, 1, 0, 0, 1, 0, 8'd3, fb));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 1, 1, 0, 1, 8'd4, fb));
    vecs.push_back(mk(0, 5'd0, 16'h0, 0, 0, 1, 0, 0, 8'd4, fb));

    rst_n = 1'b1;
    idle_inputs();

    // Asynchronous reset mid-cycle.
    #12 rst_n = 1'b0;
    #1;
    chk("rst mat", mat, zero_f);
    chk("rst wr_ready", wr_ready, 1'b1);
    chk("rst pending", pending, 1'b0);
    chk("rst swap_done", swap_done, 1'b0);
    chk("rst frame_count", frame_count, 8'd0);
    #9 rst_n = 1'b1;
    @(posedge clock); #1;
    frame_sync = 1'b1;
    @(posedge clock); #1;
    frame_sync = 1'b0;
    chk("idle sync mat", mat, zero_f);
    chk("idle sync swap_done", swap_done, 1'b0);
    chk("idle sync frame_count", frame_count, 8'd0);
    chk("idle sync pending", pending, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      wr_valid   = vecs[i].wv;
      wr_row     = vecs[i].row;
      wr_data    = vecs[i].data;
      commit     = vecs[i].cm;
      frame_sync = vecs[i].fs;
      @(posedge clock); #1;
      chk($sformatf("v%0d wr_ready", i), wr_ready, vecs[i].e_ready);
      chk($sformatf("v%0d pending", i), pending, vecs[i].e_pend);
      chk($sformatf("v%0d swap_done", i), swap_done, vecs[i].e_swap);
      chk($sformatf("v%0d frame_count", i), frame_count, vecs[i].e_cnt);
      chk($sformatf("v%0d mat", i), mat, vecs[i].e_mat);
    end
    idle_inputs();

    // Reset while PENDING discards the commit and both banks.
    commit = 1'b1;
    @(posedge clock); #1;
    commit = 1'b0;
    chk("pre-rst pending", pending, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("pend rst pending", pending, 1'b0);
    chk("pend rst wr_ready", wr_ready, 1'b1);
    chk("pend rst mat", mat, zero_f);
    chk("pend rst frame_count", frame_count, 8'd0);
    #2 rst_n = 1'b1;
    @(posedge clock); #1;
    frame_sync = 1'b1;
    @(posedge clock); #1;
    frame_sync = 1'b0;
    chk("post rst sync swap_done", swap_done, 1'b0);
    chk("post rst sync frame_count", frame_count, 8'd0);

    // 256 swaps bring frame_count back to 0.
    for (int i = 0; i < 256; i++) begin
      commit = 1'b1;
      @(posedge clock); #1;
      commit     = 1'b0;
      frame_sync = 1'b1;
      @(posedge clock); #1;
      frame_sync = 1'b0;
      if (i == 254) chk("wrap count 255", frame_count, 8'd255);
      if (i == 255) begin
        chk("wrap count 0", frame_count, 8'd0);
        chk("wrap swap_done", swap_done, 1'b1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
